// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU slice.
//   ALU_DEFAULT_WIDTH : default operand/result width
//   alu_op_e          : opcode encoding (values 5-7 are reserved)
//   div_state_e       : state encoding for the iterative divider
//   is_div_op()       : true for opcodes that go through the divider
package alu_pkg;

    localparam int ALU_DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_MUL = 3'd2,
        ALU_DIV = 3'd3,
        ALU_MOD = 3'd4
    } alu_op_e;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == ALU_DIV) || (op == ALU_MOD);
    endfunction

endpackage

// File: rtl/alu_divider.sv
// alu_divider: unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : load operands and begin (only honoured when idle)
//   dividend, divisor   : unsigned magnitudes
//   quotient, remainder : results, valid while 'valid' is high
//   valid               : one-cycle pulse, WIDTH cycles after start
// A zero divisor is not special-cased here; the caller overrides the result.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             valid_q, valid_d;
    logic [WIDTH:0]   rem_shift;

    // The quotient register doubles as the dividend shift register: each
    // step moves its MSB into the partial remainder and fills in the new
    // quotient bit at the bottom. The partial remainder is always below the
    // divisor, so WIDTH bits hold it; only the shifted trial value needs one
    // extra bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        dvsr_d    = dvsr_q;
        valid_d   = 1'b0;
        rem_shift = {rem_q, quot_q[WIDTH-1]};

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d = DIV_RUN;
                    cnt_d   = CNT_W'(WIDTH);
                    rem_d   = '0;
                    quot_d  = dividend;
                    dvsr_d  = divisor;
                end
            end
            DIV_RUN: begin
                if (rem_shift >= {1'b0, dvsr_q}) begin
                    rem_d  = WIDTH'(rem_shift - {1'b0, dvsr_q});
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DIV_IDLE;
                    valid_d = 1'b1;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            valid_q <= valid_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign valid     = valid_q;

endmodule

// File: rtl/alu.sv
// alu: registered signed ALU (add, sub, mul single-cycle; div/mod iterative).
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   tmp1, tmp2    : signed operands A and B (dividend / divisor for div, mod)
//   op            : 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5-7 reserved
//   enable        : start request, accepted when not busy
//   result        : registered signed result
//   zero          : result == 0, updated together with result
//   carry         : signed overflow / error flag
//   busy          : div/mod in progress
//   done          : one-cycle pulse after result/zero/carry update
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tmp1,
    input  logic [WIDTH-1:0] tmp2,
    input  logic [2:0]       op,
    input  logic             enable,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2:0]         op_q, op_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic               b_zero_q, b_zero_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   sum, diff;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               update;
    logic               div_start;
    logic [WIDTH-1:0]   div_quot, div_rem;
    logic               div_valid;

    alu_divider #(.WIDTH(WIDTH)) u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_quot),
        .remainder (div_rem),
        .valid     (div_valid)
    );

    // Datapath for the single-cycle ops. The product is formed from
    // sign-extended operands so its low 2*WIDTH bits are the true signed
    // product; it fits in WIDTH bits only if bits [2W-1:W-1] are all equal.
    always_comb begin
        sum   = tmp1 + tmp2;
        diff  = tmp1 - tmp2;
        a_ext = {{WIDTH{tmp1[MSB]}}, tmp1};
        b_ext = {{WIDTH{tmp2[MSB]}}, tmp2};
        prod  = a_ext * b_ext;
        mag_a = tmp1[MSB] ? -tmp1 : tmp1;
        mag_b = tmp2[MSB] ? -tmp2 : tmp2;
    end

    // Accept a new op when idle, or finish a div/mod when the divider
    // reports. For div/mod only the operand signs and special cases are
    // kept here; the divider holds the magnitudes. The most-negative
    // magnitude wraps back to itself on negation, so min/-1 naturally
    // yields min and only the flag needs remembering.
    always_comb begin
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        busy_d    = busy_q;
        op_d      = op_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        b_zero_d  = b_zero_q;
        ovf_d     = ovf_q;
        update    = 1'b0;
        div_start = 1'b0;

        if (!busy_q && enable) begin
            case (op)
                ALU_ADD: begin
                    result_d = sum;
                    carry_d  = (tmp1[MSB] == tmp2[MSB]) && (sum[MSB] != tmp1[MSB]);
                    update   = 1'b1;
                end
                ALU_SUB: begin
                    result_d = diff;
                    carry_d  = (tmp1[MSB] != tmp2[MSB]) && (diff[MSB] != tmp1[MSB]);
                    update   = 1'b1;
                end
                ALU_MUL: begin
                    result_d = prod[WIDTH-1:0];
                    carry_d  = !((&prod[2*WIDTH-1:MSB]) || !(|prod[2*WIDTH-1:MSB]));
                    update   = 1'b1;
                end
                ALU_DIV, ALU_MOD: begin
                    busy_d    = 1'b1;
                    div_start = 1'b1;
                    op_d      = op;
                    a_neg_d   = tmp1[MSB];
                    b_neg_d   = tmp2[MSB];
                    b_zero_d  = (tmp2 == '0);
                    ovf_d     = (tmp1 == {1'b1, {(WIDTH-1){1'b0}}}) && (tmp2 == '1);
                end
                default: begin
                    result_d = '0;
                    carry_d  = 1'b0;
                    update   = 1'b1;
                end
            endcase
        end else if (busy_q && div_valid) begin
            busy_d = 1'b0;
            update = 1'b1;
            if (b_zero_q) begin
                result_d = '0;
                carry_d  = 1'b1;
            end else if (op_q == ALU_DIV) begin
                result_d = (a_neg_q ^ b_neg_q) ? -div_quot : div_quot;
                carry_d  = ovf_q;
            end else begin
                result_d = a_neg_q ? -div_rem : div_rem;
                carry_d  = 1'b0;
            end
        end

        if (update) begin
            zero_d = (result_d == '0);
        end
        done_d = update;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign carry  = carry_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu (WIDTH = 16).
module tb_alu;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] tmp1;
    logic [W-1:0] tmp2;
    logic [2:0]   op;
    logic         enable;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tmp1   (tmp1),
        .tmp2   (tmp2),
        .op     (op),
        .enable (enable),
        .result (result),
        .zero   (zero),
        .carry  (carry),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issue one op, scramble the inputs after acceptance, wait for
    // completion within a bound and check outputs and latency.
    task automatic applyStimulus(input logic [2:0] opIn, input int a, input int b,
                                 input int expRes, input logic expZero, input logic expCarry,
                                 input string tag);
        int           busyCycles;
        logic [W-1:0] expVal;
        expVal = expRes[W-1:0];
        @(negedge clk);
        op     = opIn;
        tmp1   = a[W-1:0];
        tmp2   = b[W-1:0];
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        tmp1   = ~tmp1;
        tmp2   = ~tmp2;
        op     = ALU_ADD;
        busyCycles = 0;
        while (busy === 1'b1 && busyCycles < 64) begin
            busyCycles++;
            @(posedge clk);
            #1;
        end
        if (opIn == ALU_DIV || opIn == ALU_MOD)
            checkOutput({tag, " busyCycles"}, busyCycles, W + 1);
        else
            checkOutput({tag, " busyCycles"}, busyCycles, 0);
        checkOutput({tag, " done"}, {31'b0, done}, 1);
        checkOutput({tag, " result"}, {16'b0, result}, {16'b0, expVal});
        checkOutput({tag, " zero"}, {31'b0, zero}, {31'b0, expZero});
        checkOutput({tag, " carry"}, {31'b0, carry}, {31'b0, expCarry});
        @(posedge clk);
        #1;
        checkOutput({tag, " doneLow"}, {31'b0, done}, 0);
        checkOutput({tag, " hold"}, {16'b0, result}, {16'b0, expVal});
    endtask

    initial begin
        int busyCycles;
        int doneCount;

        rst_n  = 1'b0;
        enable = 1'b0;
        op     = '0;
        tmp1   = '0;
        tmp2   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset result", {16'b0, result}, 0);
        checkOutput("reset zero", {31'b0, zero}, 0);
        checkOutput("reset carry", {31'b0, carry}, 0);
        checkOutput("reset busy", {31'b0, busy}, 0);
        checkOutput("reset done", {31'b0, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(ALU_ADD, -1, 1, 0, 1'b1, 1'b0, "add -1+1");
        applyStimulus(ALU_ADD, 32767, 2, -32767, 1'b0, 1'b1, "add 32767+2");
        applyStimulus(ALU_ADD, -32767, -2, 32767, 1'b0, 1'b1, "add -32767-2");
        applyStimulus(ALU_ADD, 100, -30, 70, 1'b0, 1'b0, "add 100-30");
        applyStimulus(ALU_SUB, -7, -7, 0, 1'b1, 1'b0, "sub -7--7");
        applyStimulus(ALU_SUB, -3, -2, -1, 1'b0, 1'b0, "sub -3--2");
        applyStimulus(ALU_SUB, 32767, -2, -32767, 1'b0, 1'b1, "sub 32767--2");
        applyStimulus(ALU_SUB, -32767, 2, 32767, 1'b0, 1'b1, "sub -32767-2");
        applyStimulus(ALU_MUL, 3, 2, 6, 1'b0, 1'b0, "mul 3*2");
        applyStimulus(ALU_MUL, -3, -2, 6, 1'b0, 1'b0, "mul -3*-2");
        applyStimulus(ALU_MUL, 3, -2, -6, 1'b0, 1'b0, "mul 3*-2");
        applyStimulus(ALU_MUL, 300, 300, 24464, 1'b0, 1'b1, "mul 300*300");
        applyStimulus(ALU_MUL, -128, 256, -32768, 1'b0, 1'b0, "mul -128*256");
        applyStimulus(ALU_DIV, 15, 3, 5, 1'b0, 1'b0, "div 15/3");
        applyStimulus(ALU_DIV, -15, -3, 5, 1'b0, 1'b0, "div -15/-3");
        applyStimulus(ALU_DIV, 15, -3, -5, 1'b0, 1'b0, "div 15/-3");
        applyStimulus(ALU_DIV, -15, 3, -5, 1'b0, 1'b0, "div -15/3");
        applyStimulus(ALU_DIV, 7, 0, 0, 1'b1, 1'b1, "div 7/0");
        applyStimulus(ALU_DIV, -32768, -1, -32768, 1'b0, 1'b1, "div min/-1");
        applyStimulus(ALU_DIV, 32767, 2, 16383, 1'b0, 1'b0, "div 32767/2");
        applyStimulus(ALU_MOD, 12, 5, 2, 1'b0, 1'b0, "mod 12%5");
        applyStimulus(ALU_MOD, -12, -5, -2, 1'b0, 1'b0, "mod -12%-5");
        applyStimulus(ALU_MOD, 12, -5, 2, 1'b0, 1'b0, "mod 12%-5");
        applyStimulus(ALU_MOD, -12, 5, -2, 1'b0, 1'b0, "mod -12%5");
        applyStimulus(ALU_MOD, 12, 3, 0, 1'b1, 1'b0, "mod 12%3");
        applyStimulus(ALU_MOD, 7, 0, 0, 1'b1, 1'b1, "mod 7%0");
        applyStimulus(ALU_MOD, -32768, -1, 0, 1'b1, 1'b0, "mod min%-1");
        applyStimulus(ALU_ADD, 9, 4, 13, 1'b0, 1'b0, "add 9+4");
        applyStimulus(3'd5, 9, 4, 0, 1'b1, 1'b0, "reserved op5");
        applyStimulus(3'd7, 1, 1, 0, 1'b1, 1'b0, "reserved op7");

        // Outputs hold while idle.
        applyStimulus(ALU_SUB, 50, 8, 42, 1'b0, 1'b0, "sub 50-8");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle hold result", {16'b0, result}, 42);
        checkOutput("idle hold done", {31'b0, done}, 0);

        // Enable held high with changing inputs while busy is ignored.
        @(negedge clk);
        op     = ALU_DIV;
        tmp1   = 16'd100;
        tmp2   = 16'd7;
        enable = 1'b1;
        @(posedge clk);
        #1;
        op   = ALU_ADD;
        tmp1 = 16'd1;
        tmp2 = 16'd1;
        busyCycles = 0;
        while (busy === 1'b1 && busyCycles < 64) begin
            busyCycles++;
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        checkOutput("held-enable busyCycles", busyCycles, W + 1);
        checkOutput("held-enable done", {31'b0, done}, 1);
        checkOutput("held-enable result", {16'b0, result}, 14);
        @(posedge clk);
        #1;
        checkOutput("held-enable doneLow", {31'b0, done}, 0);
        checkOutput("held-enable hold", {16'b0, result}, 14);

        // Reset in the middle of a division, with enable asserted at the reset edge.
        @(negedge clk);
        op     = ALU_DIV;
        tmp1   = 16'd15;
        tmp2   = 16'd3;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        checkOutput("abort busy before", {31'b0, busy}, 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b1;
        op     = ALU_ADD;
        tmp1   = 16'd5;
        tmp2   = 16'd5;
        @(posedge clk);
        #1;
        checkOutput("abort result", {16'b0, result}, 0);
        checkOutput("abort zero", {31'b0, zero}, 0);
        checkOutput("abort carry", {31'b0, carry}, 0);
        checkOutput("abort busy", {31'b0, busy}, 0);
        checkOutput("abort done", {31'b0, done}, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b0;
        doneCount = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) doneCount++;
        end
        checkOutput("abort no done", doneCount, 0);
        checkOutput("abort result after", {16'b0, result}, 0);
        checkOutput("abort busy after", {31'b0, busy}, 0);

        applyStimulus(ALU_ADD, 2, 3, 5, 1'b0, 1'b0, "add after reset");
        applyStimulus(ALU_DIV, 100, 10, 10, 1'b0, 1'b0, "div after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
